// File: rtl/sys_mem_arbiter.sv
// sys_mem_arbiter
//   Shares the single-port system RAM (1-cycle read latency) between the CPU
//   and the video fetch logic. Video has fixed priority and may lock the port
//   for a burst. A wait counter forces a CPU slot after MAX_WAIT blocked cycles.
//   A lock is forcibly released after LOCK_MAX cycles.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i   CPU request (held until cpu_gnt_o)
//   cpu_gnt_o           CPU access issued this cycle (combinational)
//   cpu_rvalid_o/rdata_o            CPU read return, cycle after a read grant
//   vid_req_i/lock_i/addr_i         video read request and burst lock
//   vid_gnt_o           video read issued this cycle (combinational)
//   vid_rvalid_o/rdata_o            video read return, cycle after grant
//   mem_addr_o/we_o/wdata_o         RAM drive (combinational mux, 0 when idle)
//   mem_rdata_i         RAM read data, valid one cycle after mem_addr_o
//
// Optional build macro SYS_MEM_ARBITER_STATS_EN adds 16-bit wrapping grant and
// force-entry counters (stat_vid_cnt_o, stat_cpu_cnt_o, stat_force_cnt_o).
//
// States
//   IDLE   | video wins unless the CPU has waited MAX_WAIT cycles
//   LOCKED | video burst owns the port, CPU never granted
//   FORCE  | CPU owns the slot after a forced lock release

module sys_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 18,
    parameter int MAX_WAIT = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              vid_req_i,
    input  logic              vid_lock_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic              vid_gnt_o,
    output logic              vid_rvalid_o,
    output logic [DATA_W-1:0] vid_rdata_o,
`ifdef SYS_MEM_ARBITER_STATS_EN
    output logic [15:0]       stat_vid_cnt_o,
    output logic [15:0]       stat_cpu_cnt_o,
    output logic [15:0]       stat_force_cnt_o,
`endif
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int LOCK_W = $clog2(LOCK_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_MAX_C = LOCK_W'(LOCK_MAX);
    localparam logic [LOCK_W-1:0] LOCK_ONE   = LOCK_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOCKED, S_FORCE} state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d, lock_inc;
    logic                cpu_rd_q, vid_rd_q;
    logic [DATA_W-1:0]   cpu_rdata_q, vid_rdata_q;
    logic                force_slot;

    assign lock_inc = lock_cnt_q + LOCK_ONE;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        cpu_gnt_o  = 1'b0;
        vid_gnt_o  = 1'b0;
        force_slot = 1'b0;
        unique case (state_q)
            S_IDLE, S_FORCE: begin
                // A forced slot: entered after a lock release, or the CPU has
                // waited out its budget while still in IDLE.
                force_slot = (state_q == S_FORCE) || (wait_cnt_q == WAIT_MAX_C);
                state_d    = S_IDLE;
                if (cpu_req_i && (force_slot || !vid_req_i)) begin
                    cpu_gnt_o = 1'b1;
                end else if (vid_req_i) begin
                    vid_gnt_o = 1'b1;
                    // A single-cycle lock limit is satisfied by this grant alone.
                    if (vid_lock_i && (LOCK_MAX > 1)) begin
                        state_d    = S_LOCKED;
                        lock_cnt_d = LOCK_ONE;
                    end
                end
            end
            S_LOCKED: begin
                vid_gnt_o  = vid_req_i;
                lock_cnt_d = lock_inc;
                if (lock_inc >= LOCK_MAX_C) begin
                    state_d    = cpu_req_i ? S_FORCE : S_IDLE;
                    lock_cnt_d = '0;
                end else if (!vid_lock_i) begin
                    state_d    = S_IDLE;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (cpu_gnt_o) begin
            wait_cnt_d = '0;
        end else if (cpu_req_i && (wait_cnt_q != WAIT_MAX_C)) begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        if (cpu_gnt_o) begin
            mem_addr_o  = cpu_addr_i;
            mem_we_o    = cpu_we_i;
            mem_wdata_o = cpu_wdata_i;
        end else if (vid_gnt_o) begin
            mem_addr_o  = vid_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            lock_cnt_q  <= '0;
            cpu_rd_q    <= 1'b0;
            vid_rd_q    <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            cpu_rd_q   <= cpu_gnt_o && !cpu_we_i;
            vid_rd_q   <= vid_gnt_o;
            if (cpu_rd_q) cpu_rdata_q <= mem_rdata_i;
            if (vid_rd_q) vid_rdata_q <= mem_rdata_i;
        end
    end

    // RAM data is passed straight through in the return cycle and captured so
    // the non-owner side keeps showing its last read.
    assign cpu_rvalid_o = cpu_rd_q;
    assign vid_rvalid_o = vid_rd_q;
    assign cpu_rdata_o  = cpu_rd_q ? mem_rdata_i : cpu_rdata_q;
    assign vid_rdata_o  = vid_rd_q ? mem_rdata_i : vid_rdata_q;

`ifdef SYS_MEM_ARBITER_STATS_EN
    logic        force_entry;
    logic [15:0] stat_vid_q, stat_cpu_q, stat_force_q;

    assign force_entry = (state_q == S_IDLE && cpu_req_i && wait_cnt_q == WAIT_MAX_C) ||
                         (state_q == S_LOCKED && state_d == S_FORCE);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_vid_q   <= '0;
            stat_cpu_q   <= '0;
            stat_force_q <= '0;
        end else begin
            if (vid_gnt_o)   stat_vid_q   <= stat_vid_q + 16'd1;
            if (cpu_gnt_o)   stat_cpu_q   <= stat_cpu_q + 16'd1;
            if (force_entry) stat_force_q <= stat_force_q + 16'd1;
        end
    end

    assign stat_vid_cnt_o   = stat_vid_q;
    assign stat_cpu_cnt_o   = stat_cpu_q;
    assign stat_force_cnt_o = stat_force_q;
`endif

endmodule
